vec_gather: RTL and testbench
=============================

# vec_gather

Streaming scalar-to-vector packer that builds the packed `[Elements-1:0][NBits-1:0]` operand vectors consumed by the pipelined adder trees and other vector ops in `mlops`. It accepts one signed scalar per beat over a valid/ready handshake, fills lanes from lane 0 upward, and presents completed vectors on a valid/ready output. A fill buffer plus an output register give full-rate throughput (one vector every `Elements` beats) with no bubbles while the consumer is ready. An optional `in_last` flushes a short vector with zero padding.

## Interface
- `Elements`, default 8: lanes per output vector; must be ≥ 2.
- `NBits`, default 8: width of each lane (signed two's complement).
- `CW`, default `$clog2(Elements+1)`: width of the lane-count field (derived; not overridden).

Ports:
- `clk_in`  in  1  single clock; all logic on posedge.
- `rst_in`  in  1  synchronous, active-high reset.
- `in_data`  in  `NBits`  scalar sample.
- `in_valid`  in  1  sample valid.
- `in_last`  in  1  final sample of the current vector; qualified by `in_valid`.
- `in_ready`  out  1  block can accept a sample this cycle.
- `out_data`  out  `[Elements-1:0][NBits-1:0]`  packed vector; lane 0 holds the first sample.
- `out_count`  out  `CW`  number of valid lanes, 1..`Elements`.
- `out_valid`  out  1  vector valid.
- `out_ready`  in  1  consumer accepts the vector.

## Operation
- Accept: a beat transfers when `in_valid && in_ready`. Output transfers when `out_valid && out_ready`.
- Fill stage: lane registers `fill[Elements]`, index `idx` (0..`Elements-1`), flag `fill_full`.
  - On an accepted beat, write `in_data` into lane `idx`.
  - The beat is *completing* if `idx == Elements-1` or `in_last` = 1. Otherwise `idx` increments.
- Completing beat, output stage free: the output stage is free when `!out_valid || out_ready` in that cycle.
  - Load `out_data` with the fill lanes, with the current beat merged at lane `idx`.
  - `out_count` = `idx+1`; `out_valid` = 1.
  - Clear `fill` to zero and set `idx` = 0.
- Completing beat, output stage busy:
  - Write the lane into `fill` and set `fill_full` = 1.
  - `idx` holds and `out_count` is captured later, at transfer time, as `idx+1`.
- Pending transfer: when `fill_full` is set and the output handshake completes:
  - `out_data` loads `fill`, `out_count` loads `idx+1`, and `out_valid` stays 1.
  - `fill` is cleared, `idx` = 0, `fill_full` = 0.
- `in_ready` = `!fill_full && !rst_in` (combinational). Back-pressure happens only when both stages hold a complete vector.
- Output drained with nothing pending: `out_valid` goes to 0 on the next edge.
- Padding: lanes above `out_count-1` are always 0, because `fill` is zero-cleared at every vector start.
- Data passes through unaltered; there is no width change or sign handling.
- `in_last` together with `idx == Elements-1` behaves the same as a normal full vector.
- `in_data` and `in_last` are ignored when the beat is not accepted.

## Timing
- Reset (synchronous, `rst_in` high at an edge) sets:
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0.
  - `fill` = 0, `idx` = 0, `fill_full` = 0.
  - `in_ready` is 0 while `rst_in` is high and 1 in the first cycle after.
- Reset mid-operation discards any partial vector, pending vector and held output. No handshake completes in a reset cycle.
- Latency: completing beat accepted at edge N, with the output free, gives `out_valid` = 1 from cycle N+1.
- Throughput: with `out_ready` held 1 and `in_valid` held 1, one vector every `Elements` cycles and `in_ready` never drops.
- Stall: when `out_valid` = 1 and `out_ready` = 0:
  - Exactly one further vector is absorbed into `fill`.
  - `in_ready` falls the cycle after that vector completes.
  - `in_ready` rises the cycle after the output handshake (pending vector moved up).
- Simultaneous events: a completing beat in the same cycle as an output handshake loads directly into the output, with no stall.
- Outputs are stable while `out_valid && !out_ready`.

## Test plan
Parameters `Elements=4`, `NBits=8` for all scenarios.
- **Reset values:** assert `rst_in` for 2 cycles, then release → during reset `out_valid` = 0, `out_data` = 0, `out_count` = 0, `in_ready` = 0; `in_ready` = 1 in the first cycle after release.
- **Basic fill:** send 1, -2, 3, -4 (0x01, 0xFE, 0x03, 0xFC) with `out_ready` = 1 → one cycle after the 4th beat, `out_data` = {0xFC, 0x03, 0xFE, 0x01} (lane3..lane0), `out_count` = 4, `out_valid` for exactly 1 cycle.
- **Short vector:** send 5, 6 with `in_last` on 6 → `out_data` lanes = {0, 0, 6, 5} (lane3..lane0), `out_count` = 2. The next vector 7, 8, 9, 10 shows no residue from the short vector.
- **Back-pressure:** `out_ready` = 0, stream 12 samples continuously →
  - Vector A (1..4) is held on the output.
  - Vector B (5..8) fills; `in_ready` = 0 from the cycle after beat 8.
  - Raise `out_ready` → A is accepted; B appears next cycle; `in_ready` rises; beats 9..12 complete vector C.
  - No sample is lost or duplicated.
- **Full throughput:** `in_valid` = 1 and `out_ready` = 1 for 40 beats → 10 vectors, each `out_valid` pulse exactly 4 cycles apart, `in_ready` constantly 1.
- **Reset mid-vector:** after 2 beats, plus a stalled held vector, pulse `rst_in` → `out_valid` drops. The next 4 beats form a fresh vector starting at lane 0 with `out_count` = 4.

Source files
------------

// File: rtl/vec_gather.sv
// vec_gather: streaming scalar-to-vector packer.
//
// Accepts one signed scalar per beat and packs consecutive samples into a
// [Elements-1:0][NBits-1:0] vector, lane 0 first. A fill buffer (_p0) and an
// output register (_p1) let a new vector build while the previous one waits
// on the consumer, so throughput is one vector every Elements beats.
// Asserting in_last closes a short vector; unused upper lanes read as zero.
//
// Ports:
//   clk_in     clock, all logic on posedge
//   rst_in     synchronous active-high reset
//   in_data    scalar sample (NBits, signed)
//   in_valid   sample valid
//   in_last    last sample of the current vector (qualified by in_valid)
//   in_ready   block can take a sample this cycle
//   out_data   packed vector, lane 0 = first sample
//   out_count  number of valid lanes, 1..Elements
//   out_valid  vector valid
//   out_ready  consumer accepts the vector
module vec_gather #(
  parameter int Elements = 8,
  parameter int NBits    = 8,
  parameter int CW       = $clog2(Elements + 1)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic signed [NBits-1:0]          in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [Elements-1:0][NBits-1:0]   out_data,
  output logic [CW-1:0]                    out_count,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int IW = (Elements > 1) ? $clog2(Elements) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(Elements - 1);

  logic [Elements-1:0][NBits-1:0] fill_p0;
  logic [IW-1:0]                  idx_p0;
  logic                           fill_full_p0;

  logic [Elements-1:0][NBits-1:0] out_data_p1;
  logic [CW-1:0]                  out_count_p1;
  logic                           vld_p1;

  logic                           accept;
  logic                           completing;
  logic                           out_free;
  logic                           out_fire;
  logic [CW-1:0]                  lane_count;
  logic [Elements-1:0][NBits-1:0] merged;

  assign in_ready   = !fill_full_p0 && !rst_in;
  assign accept     = in_valid && in_ready;
  assign completing = accept && ((idx_p0 == LAST_IDX) || in_last);
  assign out_free   = !vld_p1 || out_ready;
  assign out_fire   = vld_p1 && out_ready;
  assign lane_count = CW'(idx_p0) + CW'(1);

  // Fill contents with the current beat dropped into its lane, so a completing
  // beat can go straight to the output without first landing in fill.
  always_comb begin
    merged         = fill_p0;
    merged[idx_p0] = in_data;
  end

  // ---- stage p0 (fill buffer) -> stage p1 (output register) ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fill_p0      <= '0;
      idx_p0       <= '0;
      fill_full_p0 <= 1'b0;
      out_data_p1  <= '0;
      out_count_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      // Default: a drained output with nothing replacing it goes idle.
      if (out_fire) begin
        vld_p1 <= 1'b0;
      end

      if (fill_full_p0) begin
        // A complete vector is parked in fill; it moves up once the output
        // handshakes. idx was held so it still encodes that vector's length.
        if (out_fire) begin
          out_data_p1  <= fill_p0;
          out_count_p1 <= lane_count;
          vld_p1       <= 1'b1;
          fill_p0      <= '0;
          idx_p0       <= '0;
          fill_full_p0 <= 1'b0;
        end
      end else if (accept) begin
        if (completing) begin
          if (out_free) begin
            out_data_p1  <= merged;
            out_count_p1 <= lane_count;
            vld_p1       <= 1'b1;
            fill_p0      <= '0;
            idx_p0       <= '0;
          end else begin
            fill_p0[idx_p0] <= in_data;
            fill_full_p0    <= 1'b1;
          end
        end else begin
          fill_p0[idx_p0] <= in_data;
          idx_p0          <= idx_p0 + IW'(1);
        end
      end
    end
  end

  assign out_data  = out_data_p1;
  assign out_count = out_count_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_vec_gather.sv
module tb_vec_gather;

  localparam int E  = 4;
  localparam int NB = 8;
  localparam int CW = $clog2(E + 1);

  logic                   clk_in;
  logic                   rst_in;
  logic signed [NB-1:0]   in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [E-1:0][NB-1:0]   out_data;
  logic [CW-1:0]          out_count;
  logic                   out_valid;
  logic                   out_ready;

  int total;
  int bad;

  vec_gather #(.Elements(E), .NBits(NB)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the active edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic beat(input logic [NB-1:0] d, input logic l);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    logic [31:0] e;
    total     = 0;
    bad       = 0;
    rst_in    = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // ---- reset values ----
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst_in = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- basic fill ----
    out_ready = 1'b1;
    beat(8'h01, 1'b0);
    beat(8'hFE, 1'b0);
    beat(8'h03, 1'b0);
    chk("basic_not_yet", 32'(out_valid), 32'd0);
    beat(8'hFC, 1'b0);
    idle();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data",  32'(out_data),  32'hFC03FE01);
    chk("basic_count", 32'(out_count), 32'd4);
    tick();
    chk("basic_pulse_once", 32'(out_valid), 32'd0);

    // ---- short vector, then a full one with no residue ----
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b1);
    idle();
    chk("short_valid", 32'(out_valid), 32'd1);
    chk("short_data",  32'(out_data),  32'h00000605);
    chk("short_count", 32'(out_count), 32'd2);
    beat(8'h07, 1'b0);
    beat(8'h08, 1'b0);
    beat(8'h09, 1'b0);
    beat(8'h0A, 1'b0);
    idle();
    chk("after_short_data",  32'(out_data),  32'h0A090807);
    chk("after_short_count", 32'(out_count), 32'd4);
    tick();
    chk("after_short_drain", 32'(out_valid), 32'd0);

    // ---- back-pressure ----
    out_ready = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      chk("bp_ready_ab", 32'(in_ready), 32'd1);
      beat(NB'(s), 1'b0);
    end
    chk("bp_ready_low", 32'(in_ready),  32'd0);
    chk("bp_hold_a",    32'(out_data),  32'h04030201);
    chk("bp_hold_vld",  32'(out_valid), 32'd1);
    beat(8'h09, 1'b0);   // offered but refused
    beat(8'h09, 1'b0);
    chk("bp_still_low", 32'(in_ready), 32'd0);
    chk("bp_stable_a",  32'(out_data), 32'h04030201);
    out_ready = 1'b1;
    beat(8'h09, 1'b0);   // A handshakes here; 9 still refused
    chk("bp_b_data",  32'(out_data),  32'h08070605);
    chk("bp_b_count", 32'(out_count), 32'd4);
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_ready_up", 32'(in_ready), 32'd1);
    beat(8'h09, 1'b0);
    chk("bp_b_drained", 32'(out_valid), 32'd0);
    beat(8'h0A, 1'b0);
    beat(8'h0B, 1'b0);
    beat(8'h0C, 1'b0);
    idle();
    chk("bp_c_data",  32'(out_data),  32'h0C0B0A09);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    tick();

    // ---- full throughput ----
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      beat(NB'(k + 1), 1'b0);
      if ((k % 4) == 3) begin
        e = {NB'(k + 1), NB'(k), NB'(k - 1), NB'(k - 2)};
        chk("tp_valid", 32'(out_valid), 32'd1);
        chk("tp_data",  32'(out_data),  e);
      end else begin
        chk("tp_gap", 32'(out_valid), 32'd0);
      end
    end
    idle();
    tick();

    // ---- reset mid-vector with a held output ----
    out_ready = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      beat(NB'(s), 1'b0);
    end
    idle();
    chk("mid_held", 32'(out_valid), 32'd1);
    rst_in = 1'b1;
    tick();
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_count",    32'(out_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'd0);
    rst_in    = 1'b0;
    out_ready = 1'b1;
    beat(8'h21, 1'b0);
    chk("mid_no_stale", 32'(out_valid), 32'd0);
    beat(8'h22, 1'b0);
    beat(8'h23, 1'b0);
    beat(8'h24, 1'b0);
    idle();
    chk("mid_fresh_data",  32'(out_data),  32'h24232221);
    chk("mid_fresh_count", 32'(out_count), 32'd4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
